// File: rtl/scroll_seq_pkg.sv
// scroll_seq_pkg
//   Shared types and helpers for the scrolling message sequencer.
//   seq_state_t : sequencer FSM state encoding
//   BLANK_CHAR  : character code the scrolling buffer shows as a blank
//   nibble_sel  : k-th hex nibble of a word, counted from the MSB
//   lead_zero   : 1 when nibbles 0..k (MSB-first) of a word are all zero
package scroll_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    WRITE = 3'd2,
    SHOW  = 3'd3,
    DONE  = 3'd4
  } seq_state_t;

  localparam logic [4:0] BLANK_CHAR = 5'h10;

  function automatic logic [3:0] nibble_sel(input logic [31:0] word, input logic [2:0] k);
    logic [31:0] sh;
    sh = word << {k, 2'b00};
    return sh[31:28];
  endfunction

  // Top 4*(k+1) bits of the word all zero.
  function automatic logic lead_zero(input logic [31:0] word, input logic [2:0] k);
    logic [4:0]  amt;
    logic [31:0] sh;
    amt = 5'd28 - {k, 2'b00};
    sh  = word >> amt;
    return (sh == 32'd0);
  endfunction

endpackage

// File: rtl/scroll_rr_arbiter.sv
// scroll_rr_arbiter
//   Combinational round-robin arbiter. Picks the first set request at or
//   after (last_grant_i + 1) mod N_REQ.
//   req_i        : request vector
//   last_grant_i : index of the most recently served requester
//   en_i         : arbitration enable; no grant when low
//   grant_o      : one-hot grant
//   idx_o        : binary index of the granted requester
module scroll_rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req_i,
  input  logic [$clog2(N_REQ)-1:0] last_grant_i,
  input  logic                     en_i,
  output logic [N_REQ-1:0]         grant_o,
  output logic [$clog2(N_REQ)-1:0] idx_o
);

  localparam int IDX_W = $clog2(N_REQ);

  logic found;
  int   cand;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = 0;
    if (en_i) begin
      for (int off = 1; off <= N_REQ; off++) begin
        cand = int'(last_grant_i) + off;
        if (cand >= N_REQ) cand = cand - N_REQ;
        if (!found && req_i[cand]) begin
          found         = 1'b1;
          grant_o[cand] = 1'b1;
          idx_o         = IDX_W'(cand);
        end
      end
    end
  end

endmodule

// File: rtl/scroll_msg_sequencer.sv
// scroll_msg_sequencer
//   Shares the scrolling seven-segment peripheral between N_REQ requesters.
//   A granted 32-bit word is written as N_CHARS hex characters (MSB first)
//   after a buffer clear, then scrolling is enabled for DWELL_CYCLES cycles.
//
//   Ports
//     clk, rst            : clock, asynchronous active-low reset
//     req_valid/req_data  : per-requester pending flag and 32-bit word
//     req_ready           : one-hot, 1-cycle capture acknowledge
//     done/done_id        : 1-cycle completion pulse and requester index
//     busy                : capture cycle through done cycle inclusive
//     abort               : cancel the message in progress
//     buffer_clear/_write/_data : scrolling buffer interface
//     on_off/cnt_value    : scroll enable and scroll timer top
//
//   Build option: SCROLL_SEQ_LZ_BLANK_EN sends leading zero nibbles as
//   blanks (last character always a digit).
//
//   All outputs are registered: they show the phase the FSM was in on the
//   previous cycle, so the capture cycle (req_ready) is the first CLEAR cycle.
//
//   state | meaning
//   IDLE  | waiting for a request; arbitrate and capture
//   CLEAR | issue buffer clear
//   WRITE | write N_CHARS characters
//   SHOW  | scrolling enabled, dwell counter running
//   DONE  | signal completion, update round-robin pointer
module scroll_msg_sequencer
  import scroll_seq_pkg::*;
#(
  parameter int          N_REQ          = 4,
  parameter int          N_CHARS        = 8,
  parameter int          DWELL_CYCLES   = 500_000_000,
  parameter logic [31:0] SCROLL_CNT_TOP = 32'd50_000_000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*32-1:0]      req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     done,
  output logic [$clog2(N_REQ)-1:0] done_id,
  output logic                     busy,
  input  logic                     abort,
  output logic                     buffer_clear,
  output logic                     buffer_write,
  output logic [4:0]               buffer_data,
  output logic                     on_off,
  output logic [31:0]              cnt_value
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int DW_W  = $clog2(DWELL_CYCLES + 1);

  localparam logic [DW_W-1:0]  DWELL_LOAD = DW_W'(DWELL_CYCLES);
  localparam logic [DW_W-1:0]  DWELL_ONE  = DW_W'(1);
  localparam logic [2:0]       LAST_CHAR  = 3'(N_CHARS - 1);
  localparam logic [IDX_W-1:0] LAST_INIT  = IDX_W'(N_REQ - 1);

  seq_state_t       state_q, state_d;
  logic [31:0]      word_q, word_d;
  logic [IDX_W-1:0] gid_q, gid_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [2:0]       idx_q, idx_d;
  logic [DW_W-1:0]  dwell_q, dwell_d;

  logic [N_REQ-1:0] req_ready_q, req_ready_d;
  logic             done_q, done_d;
  logic [IDX_W-1:0] done_id_q, done_id_d;
  logic             busy_q, busy_d;
  logic             clr_q, clr_d;
  logic             wr_q, wr_d;
  logic [4:0]       data_q, data_d;
  logic             on_q, on_d;
  logic [31:0]      cnt_value_q;

  logic [N_REQ-1:0] arb_grant;
  logic [IDX_W-1:0] arb_idx;
  logic [31:0]      sel_word;
  logic [3:0]       nib;
  logic [4:0]       char_out;

  scroll_rr_arbiter #(
    .N_REQ(N_REQ)
  ) u_arb (
    .req_i        (req_valid),
    .last_grant_i (last_q),
    .en_i         (state_q == IDLE),
    .grant_o      (arb_grant),
    .idx_o        (arb_idx)
  );

  always_comb begin
    sel_word = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_idx == IDX_W'(i)) sel_word = req_data[i*32 +: 32];
    end
  end

  always_comb begin
    nib = nibble_sel(word_q, idx_q);
`ifdef SCROLL_SEQ_LZ_BLANK_EN
    if ((idx_q != LAST_CHAR) && lead_zero(word_q, idx_q)) char_out = BLANK_CHAR;
    else                                                   char_out = {1'b0, nib};
`else
    char_out = {1'b0, nib};
`endif
  end

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    gid_d       = gid_q;
    last_d      = last_q;
    idx_d       = idx_q;
    dwell_d     = dwell_q;
    req_ready_d = '0;
    done_d      = 1'b0;
    done_id_d   = '0;
    busy_d      = 1'b0;
    clr_d       = 1'b0;
    wr_d        = 1'b0;
    data_d      = '0;
    on_d        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (|arb_grant) begin
          req_ready_d = arb_grant;
          word_d      = sel_word;
          gid_d       = arb_idx;
          busy_d      = 1'b1;
          state_d     = CLEAR;
        end
      end
      CLEAR: begin
        busy_d = 1'b1;
        clr_d  = 1'b1;
        idx_d  = '0;
        state_d = abort ? DONE : WRITE;
      end
      WRITE: begin
        busy_d = 1'b1;
        if (abort) begin
          clr_d   = 1'b1;
          idx_d   = '0;
          state_d = DONE;
        end else begin
          wr_d   = 1'b1;
          data_d = char_out;
          if (idx_q == LAST_CHAR) begin
            idx_d   = '0;
            dwell_d = DWELL_LOAD;
            state_d = SHOW;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      SHOW: begin
        busy_d = 1'b1;
        // Abort also wins on the terminal dwell cycle.
        if (abort) begin
          clr_d   = 1'b1;
          dwell_d = '0;
          state_d = DONE;
        end else begin
          on_d = 1'b1;
          if (dwell_q == DWELL_ONE) begin
            dwell_d = '0;
            state_d = DONE;
          end else begin
            dwell_d = dwell_q - DWELL_ONE;
          end
        end
      end
      DONE: begin
        busy_d    = 1'b1;
        done_d    = 1'b1;
        done_id_d = gid_q;
        last_d    = gid_q;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      word_q      <= '0;
      gid_q       <= '0;
      last_q      <= LAST_INIT;
      idx_q       <= '0;
      dwell_q     <= '0;
      req_ready_q <= '0;
      done_q      <= 1'b0;
      done_id_q   <= '0;
      busy_q      <= 1'b0;
      clr_q       <= 1'b0;
      wr_q        <= 1'b0;
      data_q      <= '0;
      on_q        <= 1'b0;
      cnt_value_q <= SCROLL_CNT_TOP;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      gid_q       <= gid_d;
      last_q      <= last_d;
      idx_q       <= idx_d;
      dwell_q     <= dwell_d;
      req_ready_q <= req_ready_d;
      done_q      <= done_d;
      done_id_q   <= done_id_d;
      busy_q      <= busy_d;
      clr_q       <= clr_d;
      wr_q        <= wr_d;
      data_q      <= data_d;
      on_q        <= on_d;
      cnt_value_q <= SCROLL_CNT_TOP;
    end
  end

  assign req_ready    = req_ready_q;
  assign done         = done_q;
  assign done_id      = done_id_q;
  assign busy         = busy_q;
  assign buffer_clear = clr_q;
  assign buffer_write = wr_q;
  assign buffer_data  = data_q;
  assign on_off       = on_q;
  assign cnt_value    = cnt_value_q;

endmodule

// File: tb/tb_scroll_msg_sequencer.sv
// tb_scroll_msg_sequencer
//   Self-checking bench for scroll_msg_sequencer. The reference model works
//   from a per-message timeline relative to the capture cycle and a
//   round-robin pick over the pending request vector.
module tb_scroll_msg_sequencer;

  localparam int          NREQ   = 4;
  localparam int          NC     = 8;
  localparam int          DW     = 10;
  localparam logic [31:0] TOP    = 32'h02FA_F080;
  localparam int          MAXLEN = NC + DW + 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*32-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              done;
  logic [1:0]        done_id;
  logic              busy;
  logic              abort;
  logic              buffer_clear;
  logic              buffer_write;
  logic [4:0]        buffer_data;
  logic              on_off;
  logic [31:0]       cnt_value;

  logic [31:0] words [NREQ];
  logic [15:0] obs   [MAXLEN];
  logic [15:0] expv  [MAXLEN];

  int total = 0;
  int bad   = 0;
  int m_last;

  always #5 clk = ~clk;

  always_comb begin
    req_data = '0;
    for (int i = 0; i < NREQ; i++) req_data[i*32 +: 32] = words[i];
  end

  scroll_msg_sequencer #(
    .N_REQ          (NREQ),
    .N_CHARS        (NC),
    .DWELL_CYCLES   (DW),
    .SCROLL_CNT_TOP (TOP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .done         (done),
    .done_id      (done_id),
    .busy         (busy),
    .abort        (abort),
    .buffer_clear (buffer_clear),
    .buffer_write (buffer_write),
    .buffer_data  (buffer_data),
    .on_off       (on_off),
    .cnt_value    (cnt_value)
  );

  // Output snapshot; data and id only matter while their strobes are high.
  function automatic logic [15:0] snap();
    return {req_ready, buffer_clear, buffer_write,
            (buffer_write ? buffer_data : 5'd0), on_off, done,
            (done ? done_id : 2'd0), busy};
  endfunction

  function automatic int pick(input logic [NREQ-1:0] v, input int last);
    for (int o = 1; o <= NREQ; o++) begin
      int i;
      i = (last + o) % NREQ;
      if (v[i]) return i;
    end
    return 0;
  endfunction

  function automatic logic [4:0] exp_char(input logic [31:0] w, input int k);
    logic [31:0] t;
    t = w >> (28 - 4*k);
`ifdef SCROLL_SEQ_LZ_BLANK_EN
    if (k < NC - 1 && t == 32'd0) return 5'h10;
`endif
    return {1'b0, t[3:0]};
  endfunction

  // Expected outputs for r = 0 (capture) .. len-1 (done), abort held at r=a.
  task automatic build_exp(input int id, input logic [31:0] w, input int a, output int len);
    int         done_r, end_r;
    bit         eff, cut, wr, on, clr;
    logic [3:0] rdy;
    logic [4:0] ch;
    logic [1:0] did;
    done_r = 2 + NC + DW;
    eff    = (a >= 0) && (a <= done_r - 2);
    end_r  = eff ? a + 2 : done_r;
    for (int r = 0; r <= end_r; r++) begin
      cut = eff && (r > a);
      wr  = (r >= 2) && (r <= 1 + NC) && !cut;
      on  = (r >= 2 + NC) && (r <= 1 + NC + DW) && !cut;
      clr = (r == 1) || (eff && r == a + 1);
      rdy = (r == 0) ? 4'(1 << id) : 4'd0;
      ch  = wr ? exp_char(w, r - 2) : 5'd0;
      did = (r == end_r) ? 2'(id) : 2'd0;
      expv[r] = {rdy, clr, wr, ch, on, (r == end_r), did, 1'b1};
    end
    len = end_r + 1;
  endtask

  // Waits for a capture, then records len cycles of outputs. wt = cycles
  // spent waiting (-1 on timeout).
  task automatic record_msg(input int drop_id, input int a, input int len, output int wt);
    wt = -1;
    for (int w = 0; w < 200; w++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        wt = w;
        break;
      end
    end
    if (wt < 0) return;
    for (int r = 0; r < len; r++) begin
      if (r > 0) @(negedge clk);
      obs[r] = snap();
      if (r == 0) req_valid[drop_id] = 1'b0;
      abort = (r == a);
    end
    abort = 1'b0;
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    req_valid = '0;
    abort     = 1'b0;
    repeat (2) @(negedge clk);
    rst    = 1'b1;
    m_last = NREQ - 1;
  endtask

  task automatic test_reset();
    int seen_done, seen_busy, wt;
    rst       = 1'b0;
    req_valid = '0;
    abort     = 1'b0;
    for (int i = 0; i < NREQ; i++) words[i] = '0;
    repeat (3) @(negedge clk);
    rst    = 1'b1;
    m_last = NREQ - 1;
    @(negedge clk);
    total++;
    if (snap() !== 16'h0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=%h", snap(), 16'h0);
    end
    total++;
    if (cnt_value !== TOP) begin
      bad++;
      $display("FAIL reset_cnt_value got=%h want=%h", cnt_value, TOP);
    end

    words[2]     = $urandom;
    req_valid[2] = 1'b1;
    wt = -1;
    for (int w = 0; w < 50; w++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        wt = w;
        break;
      end
    end
    req_valid = '0;
    total++;
    if (wt !== 0) begin
      bad++;
      $display("FAIL reset_mid_capture wait got=%0d want=0", wt);
    end
    repeat (4) @(negedge clk);
    total++;
    if (buffer_write !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_in_write buffer_write got=%b want=1", buffer_write);
    end
    rst = 1'b0;
    #1;
    total++;
    if ({on_off, buffer_write, busy} !== 3'b000 || snap() !== 16'h0) begin
      bad++;
      $display("FAIL reset_mid_async got=%b/%h want=000/0000", {on_off, buffer_write, busy}, snap());
    end
    total++;
    if (cnt_value !== TOP) begin
      bad++;
      $display("FAIL reset_mid_cnt_value got=%h want=%h", cnt_value, TOP);
    end
    repeat (2) @(negedge clk);
    rst    = 1'b1;
    m_last = NREQ - 1;
    seen_done = 0;
    seen_busy = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) seen_done++;
      if (busy) seen_busy++;
    end
    total++;
    if (seen_done !== 0 || seen_busy !== 0) begin
      bad++;
      $display("FAIL reset_mid_no_done done_cycles=%0d busy_cycles=%0d want=0/0", seen_done, seen_busy);
    end
  endtask

  task automatic test_single();
    int id, len, wt;
    words[1]  = 32'h1234ABCD;
    req_valid = 4'b0010;
    id = pick(req_valid, m_last);
    build_exp(id, words[id], -1, len);
    record_msg(id, -1, len, wt);
    m_last = id;
    total++;
    if (wt !== 0) begin
      bad++;
      $display("FAIL single_capture wait got=%0d want=0", wt);
    end
    for (int r = 0; r < len; r++) begin
      total++;
      if (obs[r] !== expv[r]) begin
        bad++;
        $display("FAIL single r=%0d got=%h want=%h", r, obs[r], expv[r]);
      end
    end
    @(negedge clk);
    total++;
    if (snap() !== 16'h0) begin
      bad++;
      $display("FAIL single_idle_after got=%h want=0000", snap());
    end
  endtask

  task automatic test_simultaneous();
    int id, len, wt;
    do_reset();
    words[0]  = $urandom;
    words[2]  = $urandom;
    req_valid = 4'b0101;
    for (int m = 0; m < 2; m++) begin
      id = pick(req_valid, m_last);
      build_exp(id, words[id], -1, len);
      record_msg(id, -1, len, wt);
      m_last = id;
      total++;
      if (wt !== 0) begin
        bad++;
        $display("FAIL simul_wait msg=%0d got=%0d want=0", m, wt);
      end
      for (int r = 0; r < len; r++) begin
        total++;
        if (obs[r] !== expv[r]) begin
          bad++;
          $display("FAIL simul msg=%0d r=%0d got=%h want=%h", m, r, obs[r], expv[r]);
        end
      end
    end
  endtask

  task automatic test_fairness();
    int id, len, wt;
    do_reset();
    for (int i = 0; i < NREQ; i++) words[i] = $urandom;
    req_valid = 4'b1111;
    for (int m = 0; m < 5; m++) begin
      id = pick(req_valid, m_last);
      build_exp(id, words[id], -1, len);
      record_msg(id, -1, len, wt);
      m_last = id;
      if (m < 4) begin
        words[id]     = $urandom;
        req_valid[id] = 1'b1;
      end
      total++;
      if (wt !== 0) begin
        bad++;
        $display("FAIL fair_wait msg=%0d got=%0d want=0", m, wt);
      end
      for (int r = 0; r < len; r++) begin
        total++;
        if (obs[r] !== expv[r]) begin
          bad++;
          $display("FAIL fair msg=%0d r=%0d got=%h want=%h", m, r, obs[r], expv[r]);
        end
      end
    end
  endtask

  task automatic test_abort();
    int id, len, wt;
    int points [5];
    points = '{NC + 4, 3, 0, NC + DW, NC + DW + 1};
    do_reset();
    for (int p = 0; p < 5; p++) begin
      id = $urandom_range(0, NREQ - 1);
      words[id] = $urandom;
      req_valid = 4'(1 << id);
      id = pick(req_valid, m_last);
      build_exp(id, words[id], points[p], len);
      record_msg(id, points[p], len, wt);
      m_last = id;
      total++;
      if (wt !== 0) begin
        bad++;
        $display("FAIL abort_wait a=%0d got=%0d want=0", points[p], wt);
      end
      for (int r = 0; r < len; r++) begin
        total++;
        if (obs[r] !== expv[r]) begin
          bad++;
          $display("FAIL abort a=%0d r=%0d got=%h want=%h", points[p], r, obs[r], expv[r]);
        end
      end
    end
    abort = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (snap() !== 16'h0) begin
        bad++;
        $display("FAIL abort_idle c=%0d got=%h want=0000", c, snap());
      end
    end
    abort = 1'b0;
  endtask

  task automatic test_random();
    int id, len, wt, a;
    do_reset();
    for (int m = 0; m < 10; m++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
          words[i]     = $urandom >> $urandom_range(0, 31);
          req_valid[i] = 1'b1;
        end
      end
      if (req_valid == '0) begin
        words[m % NREQ]     = $urandom;
        req_valid[m % NREQ] = 1'b1;
      end
      a  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, NC + DW + 1)) : -1;
      id = pick(req_valid, m_last);
      build_exp(id, words[id], a, len);
      record_msg(id, a, len, wt);
      m_last = id;
      total++;
      if (wt !== 0) begin
        bad++;
        $display("FAIL rand_wait msg=%0d got=%0d want=0", m, wt);
      end
      for (int r = 0; r < len; r++) begin
        total++;
        if (obs[r] !== expv[r]) begin
          bad++;
          $display("FAIL rand msg=%0d a=%0d r=%0d got=%h want=%h", m, a, r, obs[r], expv[r]);
        end
      end
    end
    req_valid = '0;
  endtask

  task automatic test_leading_zero();
    int id, len, wt;
    logic [31:0] vals [2];
    int          who  [2];
    vals = '{32'h000000A5, 32'h00000000};
    who  = '{3, 0};
    do_reset();
    for (int m = 0; m < 2; m++) begin
      words[who[m]] = vals[m];
      req_valid     = 4'(1 << who[m]);
      id = pick(req_valid, m_last);
      build_exp(id, words[id], -1, len);
      record_msg(id, -1, len, wt);
      m_last = id;
      total++;
      if (wt !== 0) begin
        bad++;
        $display("FAIL lz_wait msg=%0d got=%0d want=0", m, wt);
      end
      for (int r = 0; r < len; r++) begin
        total++;
        if (obs[r] !== expv[r]) begin
          bad++;
          $display("FAIL lz word=%h r=%0d got=%h want=%h", vals[m], r, obs[r], expv[r]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_abort();
    test_random();
    test_leading_zero();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/scroll_msg_sequencer.md
Name: scroll_msg_sequencer

Overview:
- Shares the scrolling seven-segment peripheral between N_REQ on-chip requesters, such as CAN node status and error reporters.
- Each requester hands over one 32-bit hex word.
- The block arbitrates round-robin, clears the scrolling buffer, writes the word as N_CHARS characters and enables scrolling for a fixed dwell time.
- It then releases the display and signals completion.
- Sits in front of the scrolling buffer, timer and controller, in place of software register writes.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- N_CHARS, 8, characters written per message, taken MSB-first from the 32-bit word (1..8).
- DWELL_CYCLES, 500_000_000, clk cycles on_off stays high per message (>=1).
- SCROLL_CNT_TOP, 50_000_000, scroll timer top value driven on cnt_value.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  N_REQ  requester i has a message pending
- req_data  in  N_REQ x 32  message word per requester
- req_ready  out  N_REQ  one-hot; pulses 1 cycle when requester i's word is captured
- done  out  1  1-cycle pulse when a message finishes
- done_id  out  $clog2(N_REQ)  requester index of the finished message (valid with done)
- busy  out  1  high from the capture cycle until the done cycle inclusive
- abort  in  1  cancel the current message
- buffer_clear  out  1  clear pulse to the scrolling buffer
- buffer_write  out  1  write strobe to the scrolling buffer
- buffer_data  out  5  character: bit4=1 is blank, else [3:0] is a hex digit
- on_off  out  1  scrolling enable
- cnt_value  out  32  scroll timer top

Behaviour:
- Reset values:
  - All outputs are 0, except cnt_value = SCROLL_CNT_TOP.
  - State is IDLE.
  - The round-robin pointer is set so requester 0 has highest priority.
  - The dwell counter and character index are 0.
  - All outputs are registered.
- FSM states: IDLE, CLEAR, WRITE, SHOW, DONE.
- IDLE:
  - If any req_valid is set, grant the first set bit at or after (last_grant+1) mod N_REQ.
  - In the same cycle, assert req_ready[g], latch req_data[g] and g, and go to CLEAR.
  - If no req_valid is set, stay in IDLE.
- CLEAR: buffer_clear=1 for exactly one cycle; then WRITE.
- WRITE:
  - Lasts N_CHARS consecutive cycles with buffer_write=1.
  - On write k (k=0..N_CHARS-1), buffer_data = {1'b0, word[31-4k -: 4]}.
  - After the last write, go to SHOW.
- SHOW: on_off=1 for exactly DWELL_CYCLES cycles, counted by a $clog2(DWELL_CYCLES+1)-bit counter; then DONE.
- DONE:
  - on_off=0, done=1 and done_id=g for one cycle.
  - The pointer is updated to g; go to IDLE.
- Timing: with capture at cycle T:
  - Clear occurs at T+1.
  - Writes occur at T+2 .. T+1+N_CHARS.
  - on_off is high from T+2+N_CHARS for DWELL_CYCLES cycles.
  - done follows the last on_off cycle.
  - The earliest next capture is the cycle after done.
- req_ready is never asserted outside IDLE. A requester must hold req_valid and req_data until it sees req_ready.
- abort:
  - In CLEAR, WRITE or SHOW, abort forces on_off=0 and a buffer_clear pulse next cycle.
  - It then goes to DONE, so done still pulses with done_id.
  - abort is ignored in IDLE and DONE.
  - If abort coincides with the last SHOW cycle, the abort path wins and a clear pulse is issued.
- buffer_clear and buffer_write are never high in the same cycle.
- Reset asserted mid-operation returns immediately to IDLE. All outputs go to their reset values and no done is produced.

Optional Feature:
- Macro: SCROLL_SEQ_LZ_BLANK_EN.
- Defined:
  - Leading zero nibbles of the written characters are sent as 5'h10 (blank).
  - The final character is always sent as a hex digit, so 0 displays as blanks followed by "0".
  - The write count is still N_CHARS.
- Undefined: every nibble is sent as {1'b0, nibble}.

Decomposition:
- Package scroll_seq_pkg:
  - State enum seq_state_t (IDLE, CLEAR, WRITE, SHOW, DONE).
  - BLANK_CHAR = 5'h10.
  - Function nibble_sel(word, k).
- Sub-module scroll_rr_arbiter (parameter N_REQ):
  - Inputs: req, last_grant, en.
  - Outputs: one-hot grant and binary index, combinational.
  - Reused by the sequencer's IDLE state.

Test Plan:
1. Reset check: after rst release, all outputs are 0, cnt_value=SCROLL_CNT_TOP and busy=0. Asserting rst low mid-WRITE makes on_off, buffer_write and busy go to 0 at once, with no done.
2. Single message: req_valid[1]=1, data 32'h1234ABCD, DWELL_CYCLES=10.
   - req_ready=4'b0010 at T.
   - Clear at T+1.
   - buffer_data 01,02,03,04,0A,0B,0C,0D at T+2..T+9.
   - on_off high T+10..T+19.
   - done=1 with done_id=1 at T+20.
3. Simultaneous requests: req_valid=4'b0101 from reset gives grant 0 first. Requester 2 is served after done, with its ready pulse one cycle after done.
4. Fairness: req_valid=4'b1111 held gives grant order 0,1,2,3,0. No requester is served twice before the others.
5. Abort: abort pulsed during the 3rd SHOW cycle gives on_off=0 and buffer_clear=1 next cycle, then done with the correct done_id.
6. With SCROLL_SEQ_LZ_BLANK_EN defined:
   - 32'h000000A5 writes 10,10,10,10,10,10,0A,05.
   - 32'h0 writes seven 5'h10 then 5'h00.
